dpram_fifo: RTL and testbench

//  Synchronous FIFO controller that drives an external dpram instance:
//  - dpram port A is used as the write port.
//  - dpram port X is used as the read port.

---
 rtl/dpram_fifo.sv | 70 +++++++
 tb/tb_dpram_fifo.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dpram_fifo.sv
// FIFO controller for an external dual-port RAM: port A writes, port X reads.
// Flags are decoded from registered state only; read address is looked ahead on pop.
module dpram_fifo #(
   parameter int AW = 5,
   parameter int DW = 2
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          flush_i,
   input  logic [DW-1:0] wdat_i,
   input  logic          wvld_i,
   output logic          wrdy_o,
   output logic [DW-1:0] rdat_o,
   output logic          rvld_o,
   input  logic          rrdy_i,
   output logic [AW:0]   lvl_o,
   output logic [AW-1:0] mem_adr_o,
   output logic [DW-1:0] mem_dat_o,
   output logic          mem_wre_o,
   output logic [AW-1:0] mem_xadr_o,
   output logic          mem_ena_o,
   input  logic [DW-1:0] mem_xdat_i
);

   localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   cnt;
   logic          push;
   logic          pop;

   assign wrdy_o = (cnt != FULL);
   assign rvld_o = (cnt != '0);
   assign lvl_o  = cnt;

   // No RAM write may leak out while the controller is held in reset.
   assign push = wvld_i & wrdy_o & ~flush_i & rst_ni;
   assign pop  = rvld_o & rrdy_i & ~flush_i;

   assign mem_adr_o  = wptr;
   assign mem_dat_o  = wdat_i;
   assign mem_wre_o  = push;
   assign mem_ena_o  = 1'b1;

   // The RAM registers the read address, so present the post-pop head now.
   assign mem_xadr_o = pop ? rptr + AW'(1) : rptr;
   assign rdat_o     = mem_xdat_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else if (flush_i) begin
         wptr <= '0;
         rptr <= '0;
         cnt  <= '0;
      end else begin
         if (push) wptr <= wptr + AW'(1);
         if (pop)  rptr <= rptr + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + (AW+1)'(1);
            2'b01:   cnt <= cnt - (AW+1)'(1);
            default: cnt <= cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_dpram_fifo.sv
// Directed bench for dpram_fifo with a behavioural registered-address dual-port RAM.
module tb_dpram_fifo;

   localparam int AW = 5;
   localparam int DW = 2;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic [DW-1:0] wdat;
   logic          wvld;
   logic          wrdy;
   logic [DW-1:0] rdat;
   logic          rvld;
   logic          rrdy;
   logic [AW:0]   lvl;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_dat;
   logic          mem_wre;
   logic [AW-1:0] mem_xadr;
   logic          mem_ena;
   logic [DW-1:0] mem_xdat;

   int total = 0;
   int bad = 0;
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_head;

   dpram_fifo #(.AW(AW), .DW(DW)) dut (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
      .wdat_i(wdat), .wvld_i(wvld), .wrdy_o(wrdy),
      .rdat_o(rdat), .rvld_o(rvld), .rrdy_i(rrdy), .lvl_o(lvl),
      .mem_adr_o(mem_adr), .mem_dat_o(mem_dat), .mem_wre_o(mem_wre),
      .mem_xadr_o(mem_xadr), .mem_ena_o(mem_ena), .mem_xdat_i(mem_xdat)
   );

   // RAM model: registered read address, combinational array read gives write-through.
   logic [DW-1:0] ram [1<<AW];
   logic [AW-1:0] xadr_q;
   always_ff @(posedge clk) begin
      if (mem_wre && mem_ena) ram[mem_adr] <= mem_dat;
      xadr_q <= mem_xadr;
   end
   assign mem_xdat = ram[xadr_q];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      wdat  = '0;
      wvld  = 1'b0;
      rrdy  = 1'b0;

      // Reset with random inputs.
      for (int i = 0; i < 3; i++) begin
         wvld  = 1'($urandom);
         rrdy  = 1'($urandom);
         flush = 1'($urandom);
         wdat  = DW'($urandom);
         wvld  = 1'b1;
         #1;
         check_output("rst_wre", 32'(mem_wre), 32'd0);
         tick();
      end
      check_output("rst_rvld", 32'(rvld), 32'd0);
      check_output("rst_wrdy", 32'(wrdy), 32'd1);
      check_output("rst_lvl", 32'(lvl), 32'd0);
      check_output("rst_ena", 32'(mem_ena), 32'd1);

      wvld = 1'b0; rrdy = 1'b0; flush = 1'b0;
      rst_n = 1'b1;
      tick();

      // Latency into an empty FIFO.
      wdat = 2'b10; wvld = 1'b1;
      #1;
      check_output("lat_wre", 32'(mem_wre), 32'd1);
      check_output("lat_adr", 32'(mem_adr), 32'd0);
      tick();
      wvld = 1'b0;
      check_output("lat_rvld", 32'(rvld), 32'd1);
      check_output("lat_rdat", 32'(rdat), 32'h2);
      check_output("lat_lvl", 32'(lvl), 32'd1);
      rrdy = 1'b1;
      tick();
      rrdy = 1'b0;
      check_output("lat_pop_lvl", 32'(lvl), 32'd0);
      check_output("lat_pop_rvld", 32'(rvld), 32'd0);

      // Fill to full.
      for (int i = 0; i < 32; i++) begin
         wdat = DW'(i); wvld = 1'b1;
         q.push_back(DW'(i));
         tick();
      end
      check_output("fill_lvl", 32'(lvl), 32'd32);
      check_output("fill_wrdy", 32'(wrdy), 32'd0);
      wdat = 2'b11;
      #1;
      check_output("fill_drop_wre", 32'(mem_wre), 32'd0);
      tick();
      wvld = 1'b0;
      check_output("fill_drop_lvl", 32'(lvl), 32'd32);

      // Drain in push order.
      rrdy = 1'b1;
      for (int i = 0; i < 32; i++) begin
         #1;
         exp_head = q.pop_front();
         check_output($sformatf("drain_%0d", i), 32'(rdat), 32'(exp_head));
         tick();
      end
      rrdy = 1'b0;
      check_output("drain_rvld", 32'(rvld), 32'd0);
      check_output("drain_lvl", 32'(lvl), 32'd0);

      // Empty with pop request only: ignored.
      rrdy = 1'b1;
      tick();
      rrdy = 1'b0;
      check_output("empty_pop_lvl", 32'(lvl), 32'd0);

      // Steady push/pop at level 1 across pointer wrap.
      wdat = 2'b01; wvld = 1'b1;
      q.push_back(2'b01);
      tick();
      rrdy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         wdat = DW'(i * 3 + 2);
         #1;
         exp_head = q.pop_front();
         check_output($sformatf("wrap_dat_%0d", i), 32'(rdat), 32'(exp_head));
         q.push_back(DW'(i * 3 + 2));
         tick();
         check_output($sformatf("wrap_lvl_%0d", i), 32'(lvl), 32'd1);
      end
      wvld = 1'b0;
      tick();
      exp_head = q.pop_front();
      rrdy = 1'b0;
      check_output("wrap_end_lvl", 32'(lvl), 32'd0);

      // Flush at level 5 with a push pending.
      for (int i = 0; i < 5; i++) begin
         wdat = DW'(i + 1); wvld = 1'b1;
         tick();
      end
      check_output("flush_pre_lvl", 32'(lvl), 32'd5);
      flush = 1'b1; wdat = 2'b11;
      #1;
      check_output("flush_wre", 32'(mem_wre), 32'd0);
      tick();
      flush = 1'b0; wvld = 1'b0;
      check_output("flush_lvl", 32'(lvl), 32'd0);
      check_output("flush_rvld", 32'(rvld), 32'd0);
      check_output("flush_wrdy", 32'(wrdy), 32'd1);
      check_output("flush_adr", 32'(mem_adr), 32'd0);

      // First push after flush goes to address 0 and is visible next cycle.
      wdat = 2'b01; wvld = 1'b1;
      q.push_back(2'b01);
      tick();
      check_output("post_flush_rdat", 32'(rdat), 32'h1);
      check_output("post_flush_lvl", 32'(lvl), 32'd1);

      // Full with simultaneous pop: only the pop happens.
      for (int i = 1; i < 32; i++) begin
         wdat = DW'(i + 2);
         q.push_back(DW'(i + 2));
         tick();
      end
      check_output("full2_lvl", 32'(lvl), 32'd32);
      wdat = 2'b00; rrdy = 1'b1;
      #1;
      check_output("full_pop_wre", 32'(mem_wre), 32'd0);
      exp_head = q.pop_front();
      check_output("full_pop_rdat", 32'(rdat), 32'(exp_head));
      tick();
      wvld = 1'b0; rrdy = 1'b0;
      check_output("full_pop_lvl", 32'(lvl), 32'd31);
      check_output("full_pop_wrdy", 32'(wrdy), 32'd1);
      exp_head = q[0];
      check_output("full_pop_next", 32'(rdat), 32'(exp_head));

      // Asynchronous reset mid-stream.
      #2;
      rst_n = 1'b0;
      #1;
      check_output("arst_lvl", 32'(lvl), 32'd0);
      check_output("arst_rvld", 32'(rvld), 32'd0);
      check_output("arst_wrdy", 32'(wrdy), 32'd1);
      tick();
      rst_n = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
